// File: rtl/share_align_3n_if.sv
// Bundle of the three share handshakes, flush and the presented sharing.
// Build option SHARE_ALIGN_REFRESH_EN adds the rnd refresh input.
interface share_align_3n_if #(
  parameter int unsigned N = 8
);
  logic         in0_valid;
  logic         in0_ready;
  logic [N-1:0] in0_data;
  logic         in1_valid;
  logic         in1_ready;
  logic [N-1:0] in1_data;
  logic         in2_valid;
  logic         in2_ready;
  logic [N-1:0] in2_data;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] y0;
  logic [N-1:0] y1;
  logic [N-1:0] y2;
`ifdef SHARE_ALIGN_REFRESH_EN
  logic [2*N-1:0] rnd;
`endif

  // Upstream/downstream side (drives shares, flush and consume)
  modport master (
`ifdef SHARE_ALIGN_REFRESH_EN
    output rnd,
`endif
    output in0_valid, in0_data, in1_valid, in1_data, in2_valid, in2_data,
    output flush, out_ready,
    input  in0_ready, in1_ready, in2_ready, out_valid, y0, y1, y2
  );

  // Aligner side
  modport slave (
`ifdef SHARE_ALIGN_REFRESH_EN
    input  rnd,
`endif
    input  in0_valid, in0_data, in1_valid, in1_data, in2_valid, in2_data,
    input  flush, out_ready,
    output in0_ready, in1_ready, in2_ready, out_valid, y0, y1, y2
  );
endinterface

// File: rtl/share_align_3n.sv
// Capture stage ahead of the 3-share recombination XOR: collects three
// Boolean shares on independent handshakes and presents them together,
// from registers, only once all three are held.
// Build option SHARE_ALIGN_REFRESH_EN re-masks the shares with rnd in ALIGN.
module share_align_3n #(
  parameter int unsigned N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  share_align_3n_if.slave        sa
);

  localparam int unsigned NSHARE = 3;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ALIGN   = 2'd1,
    PRESENT = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic [NSHARE-1:0]            full_q, full_d;
  logic [NSHARE-1:0][N-1:0]     slot_q, slot_d;
  logic [NSHARE-1:0][N-1:0]     y_q, y_d;
  logic                         out_valid_q, out_valid_d;

  logic [NSHARE-1:0]            valid;
  logic [NSHARE-1:0]            ready_c;
  logic [NSHARE-1:0][N-1:0]     data;

  assign valid = {sa.in2_valid, sa.in1_valid, sa.in0_valid};
  assign data  = {sa.in2_data, sa.in1_data, sa.in0_data};

  // A slot is open only while collecting, empty, not flushing and out of reset
  always_comb begin
    for (int k = 0; k < NSHARE; k++) begin
      ready_c[k] = (state_q == COLLECT) && !full_q[k] && !sa.flush && !rst;
    end
  end

  assign sa.in0_ready = ready_c[0];
  assign sa.in1_ready = ready_c[1];
  assign sa.in2_ready = ready_c[2];
  assign sa.out_valid = out_valid_q;
  assign sa.y0        = y_q[0];
  assign sa.y1        = y_q[1];
  assign sa.y2        = y_q[2];

  // Next-state: capture, isolation cycle, present/consume; flush wins
  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    slot_d      = slot_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;

    if (sa.flush) begin
      state_d     = COLLECT;
      full_d      = '0;
      slot_d      = '0;
      y_d         = '0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          // Registered full flags gate the move, so the last capture is
          // followed by one settled COLLECT cycle before ALIGN.
          if (&full_q) begin
            state_d = ALIGN;
          end
          for (int k = 0; k < NSHARE; k++) begin
            if (valid[k] && ready_c[k]) begin
              slot_d[k] = data[k];
              full_d[k] = 1'b1;
            end
          end
        end
        ALIGN: begin
`ifdef SHARE_ALIGN_REFRESH_EN
          y_d[0] = slot_q[0] ^ sa.rnd[N-1:0];
          y_d[1] = slot_q[1] ^ sa.rnd[2*N-1:N];
          y_d[2] = slot_q[2] ^ sa.rnd[N-1:0] ^ sa.rnd[2*N-1:N];
`else
          y_d    = slot_q;
`endif
          out_valid_d = 1'b1;
          state_d     = PRESENT;
        end
        PRESENT: begin
          if (sa.out_ready) begin
            state_d     = COLLECT;
            full_d      = '0;
            slot_d      = '0;
            y_d         = '0;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = COLLECT;
        end
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      full_q      <= '0;
      slot_q      <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      slot_q      <= slot_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_share_align_3n.sv
// Directed bench for share_align_3n: table-driven per-cycle vectors plus
// hand-written backpressure, flush, async-reset and refresh sequences.
module tb_share_align_3n;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  share_align_3n_if #(.N(8)) sa();

  share_align_3n #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .sa  (sa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] v;
    logic [7:0] d0, d1, d2;
    logic       fl;
    logic       orr;
    logic [2:0] rdy;   // ready seen during the cycle (before the edge)
    logic       ov;    // out_valid after the edge
    logic [7:0] y0, y1, y2;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [2:0] v, input logic [7:0] d0,
                              input logic [7:0] d1, input logic [7:0] d2,
                              input logic fl, input logic orr,
                              input logic [2:0] rdy, input logic ov,
                              input logic [7:0] y0, input logic [7:0] y1,
                              input logic [7:0] y2);
    vec_t r;
    r.v = v; r.d0 = d0; r.d1 = d1; r.d2 = d2; r.fl = fl; r.orr = orr;
    r.rdy = rdy; r.ov = ov; r.y0 = y0; r.y1 = y1; r.y2 = y2;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] rdy_now();
    return {sa.in2_ready, sa.in1_ready, sa.in0_ready};
  endfunction

  task automatic drive(input logic [2:0] v, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [7:0] d2,
                       input logic fl, input logic orr);
    sa.in0_valid = v[0]; sa.in1_valid = v[1]; sa.in2_valid = v[2];
    sa.in0_data  = d0;   sa.in1_data  = d1;   sa.in2_data  = d2;
    sa.flush     = fl;   sa.out_ready = orr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic ov,
                         input logic [7:0] y0, input logic [7:0] y1,
                         input logic [7:0] y2);
    chk({name, ".ov"}, 32'(sa.out_valid), 32'(ov));
    chk({name, ".y0"}, 32'(sa.y0), 32'(y0));
    chk({name, ".y1"}, 32'(sa.y1), 32'(y1));
    chk({name, ".y2"}, 32'(sa.y2), 32'(y2));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
`ifdef SHARE_ALIGN_REFRESH_EN
    sa.rnd = 16'h0000;
`endif

    // Simultaneous arrival
    tbl.push_back(mk(3'b111, 8'h3C, 8'hA5, 8'h5A, 0, 1, 3'b111, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 3'b000, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 3'b000, 1, 8'h3C, 8'hA5, 8'h5A));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 3'b000, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 3'b111, 0, 8'h00, 8'h00, 8'h00));
    // Staggered arrival: share 1 at edge 0, share 2 at edge 3, share 0 at edge 5
    tbl.push_back(mk(3'b010, 8'h11, 8'h66, 8'h99, 0, 1, 3'b111, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(3'b010, 8'h11, 8'h66, 8'h99, 0, 1, 3'b101, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(3'b010, 8'h11, 8'h66, 8'h99, 0, 1, 3'b101, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(3'b110, 8'h11, 8'h66, 8'h99, 0, 1, 3'b101, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(3'b110, 8'h11, 8'h66, 8'h99, 0, 1, 3'b001, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(3'b111, 8'h11, 8'h66, 8'h99, 0, 1, 3'b001, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 3'b000, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 3'b000, 1, 8'h11, 8'h66, 8'h99));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 3'b000, 0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 8'h00, 0, 1, 3'b111, 0, 8'h00, 8'h00, 8'h00));

    // Reset state
    #12;
    chk("reset.rdy", 32'(rdy_now()), 32'h0);
    chk_out("reset", 1'b0, 8'h00, 8'h00, 8'h00);
    rst = 1'b0;
    step();

    // Table-driven cycles
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].fl, tbl[i].orr);
      #1;
      chk($sformatf("vec%0d.rdy", i), 32'(rdy_now()), 32'(tbl[i].rdy));
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].ov, tbl[i].y0, tbl[i].y1, tbl[i].y2);
      if (tbl[i].ov)
        chk($sformatf("vec%0d.xor", i), 32'(sa.y0 ^ sa.y1 ^ sa.y2),
            32'(tbl[i].y0 ^ tbl[i].y1 ^ tbl[i].y2));
    end
    chk("simul.xor_const", 32'(tbl[2].y0 ^ tbl[2].y1 ^ tbl[2].y2) ^ 32'(sa.y0), 32'hC3);

    // Backpressure: hold PRESENT for 10 cycles
    drive(3'b111, 8'h12, 8'h34, 8'h56, 0, 0);
    step();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 0, 0);
    step();
    step();
    chk_out("bp.enter", 1'b1, 8'h12, 8'h34, 8'h56);
    for (int c = 0; c < 10; c++) begin
      step();
      chk_out($sformatf("bp.hold%0d", c), 1'b1, 8'h12, 8'h34, 8'h56);
      chk($sformatf("bp.rdy%0d", c), 32'(rdy_now()), 32'h0);
    end
    sa.out_ready = 1'b1;
    step();
    chk_out("bp.consumed", 1'b0, 8'h00, 8'h00, 8'h00);

    // Flush: shares 0 and 2 captured, flush coincides with share 1
    drive(3'b101, 8'hAA, 8'h00, 8'hBB, 0, 1);
    step();
    drive(3'b010, 8'h00, 8'hCC, 8'h00, 1, 1);
    #1;
    chk("flush.rdy_during", 32'(rdy_now()), 32'h0);
    step();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 0, 1);
    #1;
    chk("flush.rdy_after", 32'(rdy_now()), 32'h7);
    chk_out("flush.after", 1'b0, 8'h00, 8'h00, 8'h00);
    drive(3'b111, 8'h0F, 8'hF0, 8'h33, 0, 1);
    step();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 0, 1);
    step();
    chk("flush.align_ov", 32'(sa.out_valid), 32'h0);
    step();
    chk_out("flush.new", 1'b1, 8'h0F, 8'hF0, 8'h33);
    step();
    chk_out("flush.consumed", 1'b0, 8'h00, 8'h00, 8'h00);

    // Flush during PRESENT drops the sharing
    drive(3'b111, 8'h5A, 8'h5A, 8'h5A, 0, 0);
    step();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 0, 0);
    step();
    step();
    chk("flushp.ov", 32'(sa.out_valid), 32'h1);
    sa.flush = 1'b1;
    step();
    sa.flush = 1'b0;
    chk_out("flushp.after", 1'b0, 8'h00, 8'h00, 8'h00);
    sa.out_ready = 1'b1;

    // Async reset while PRESENT
    drive(3'b111, 8'h77, 8'h88, 8'h99, 0, 0);
    step();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 0, 0);
    step();
    step();
    chk_out("arst.present", 1'b1, 8'h77, 8'h88, 8'h99);
    #2;
    rst = 1'b1;
    #1;
    chk_out("arst.noedge", 1'b0, 8'h00, 8'h00, 8'h00);
    chk("arst.rdy", 32'(rdy_now()), 32'h0);
    #2;
    rst = 1'b0;
    step();
    chk("arst.rdy_after", 32'(rdy_now()), 32'h7);
    drive(3'b111, 8'h01, 8'h02, 8'h04, 0, 1);
    step();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 0, 1);
    step();
    step();
    chk_out("arst.post", 1'b1, 8'h01, 8'h02, 8'h04);
    step();
    chk_out("arst.consumed", 1'b0, 8'h00, 8'h00, 8'h00);

    // Refresh (or plain copy in the default build)
`ifdef SHARE_ALIGN_REFRESH_EN
    sa.rnd = 16'hF00F;
`endif
    drive(3'b111, 8'h11, 8'h22, 8'h44, 0, 1);
    step();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 0, 1);
    step();
    step();
`ifdef SHARE_ALIGN_REFRESH_EN
    chk_out("refresh", 1'b1, 8'h1E, 8'hD2, 8'hBB);
`else
    chk_out("copy", 1'b1, 8'h11, 8'h22, 8'h44);
`endif
    chk("refresh.xor", 32'(sa.y0 ^ sa.y1 ^ sa.y2), 32'h77);
    step();
    chk_out("refresh.consumed", 1'b0, 8'h00, 8'h00, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
